// File: rtl/pe_link_sink1100_if.sv
// Link-side and core-side signal bundle for the PE receive endpoint.
// master = upstream links plus PE core (bench side); slave = the endpoint itself.
interface pe_link_sink1100_if #(
    parameter int DATA_WIDTH  = 128,
    parameter int WEST_WIDTH  = 130,
    parameter int NORTH_WIDTH = 130
);
    logic [WEST_WIDTH-1:0]  in_from_west;
    logic [NORTH_WIDTH-1:0] in_from_north;
    logic [WEST_WIDTH-1:0]  out_to_west;
    logic [NORTH_WIDTH-1:0] out_to_north;
    logic [DATA_WIDTH-1:0]  out_data;
    logic                   out_src;
    logic                   out_valid;
    logic                   out_ready;
    logic [1:0]             overflow;
    logic [31:0]            word_count;

    modport master (
        output in_from_west,
        output in_from_north,
        output out_ready,
        input  out_to_west,
        input  out_to_north,
        input  out_data,
        input  out_src,
        input  out_valid,
        input  overflow,
        input  word_count
    );

    modport slave (
        input  in_from_west,
        input  in_from_north,
        input  out_ready,
        output out_to_west,
        output out_to_north,
        output out_data,
        output out_src,
        output out_valid,
        output overflow,
        output word_count
    );
endinterface

// File: rtl/pe_link_sink1100.sv
// West/north mesh-link receive endpoint: per-link FIFO, registered credit return, round-robin merge.
// Latency: link word to out_data in 2 edges; out_valid holds while out_ready is low, FIFOs keep absorbing.

module pe_link_sink1100_fifo #(
    parameter int W  = 128,
    parameter int AW = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic         empty_o,
    output logic         drop_o
);
    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          full;
    logic          wr_en;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    // A full FIFO still takes a push when the head is leaving on the same edge.
    assign wr_en   = push_i && (!full || pop_i);
    assign drop_o  = push_i && full && !pop_i;
    assign dout_o  = mem_q[rd_q];

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (wr_en) begin
            wr_d = wr_q + 1'b1;
        end
        if (pop_i) begin
            rd_d = rd_q + 1'b1;
        end
        case ({wr_en, pop_i})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_q] <= din_i;
        end
    end
endmodule

module pe_link_sink1100 #(
    parameter int DATA_WIDTH     = 128,
    parameter int WEST_WIDTH     = 130,
    parameter int NORTH_WIDTH    = 130,
    parameter int FIFO_ADDR_BITS = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ap_start,
    pe_link_sink1100_if.slave   lnk
);
    typedef enum logic {PTR_WEST = 1'b0, PTR_NORTH = 1'b1} ptr_e;

    localparam int VLD_BIT = DATA_WIDTH + 1;

    logic                  w_push, n_push;
    logic [DATA_WIDTH-1:0] w_dout, n_dout;
    logic                  w_empty, n_empty;
    logic                  w_drop, n_drop;
    logic                  w_pop, n_pop;
    logic                  load;
    logic                  grant_n;
    logic                  unused_bits;

    ptr_e                  ptr_q, ptr_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_src_q, out_src_d;
    logic                  cred_w_q, cred_w_d;
    logic                  cred_n_q, cred_n_d;
    logic [1:0]            ovf_q, ovf_d;
    logic [31:0]           cnt_q, cnt_d;

    assign w_push = lnk.in_from_west[VLD_BIT];
    assign n_push = lnk.in_from_north[VLD_BIT];
    assign unused_bits = lnk.in_from_west[DATA_WIDTH] ^ lnk.in_from_north[DATA_WIDTH];

    pe_link_sink1100_fifo #(.W(DATA_WIDTH), .AW(FIFO_ADDR_BITS)) u_west_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .din_i   (lnk.in_from_west[DATA_WIDTH-1:0]),
        .dout_o  (w_dout),
        .empty_o (w_empty),
        .drop_o  (w_drop)
    );

    pe_link_sink1100_fifo #(.W(DATA_WIDTH), .AW(FIFO_ADDR_BITS)) u_north_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (n_push),
        .pop_i   (n_pop),
        .din_i   (lnk.in_from_north[DATA_WIDTH-1:0]),
        .dout_o  (n_dout),
        .empty_o (n_empty),
        .drop_o  (n_drop)
    );

    // Pointer link wins when it has data; the other link is the fallback.
    assign grant_n = (ptr_q == PTR_NORTH) ? !n_empty : w_empty;
    assign load    = ap_start && (!w_empty || !n_empty) && (!out_valid_q || lnk.out_ready);
    assign w_pop   = load && !grant_n;
    assign n_pop   = load && grant_n;

    always_comb begin
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q && !lnk.out_ready;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        cred_w_d    = w_pop;
        cred_n_d    = n_pop;
        ovf_d       = ovf_q | {n_drop, w_drop};
        cnt_d       = cnt_q + 32'(out_valid_q && lnk.out_ready);
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = grant_n ? n_dout : w_dout;
            out_src_d   = grant_n;
            ptr_d       = grant_n ? PTR_WEST : PTR_NORTH;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q       <= PTR_WEST;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= 1'b0;
            cred_w_q    <= 1'b0;
            cred_n_q    <= 1'b0;
            ovf_q       <= 2'b00;
            cnt_q       <= '0;
        end else begin
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            cred_w_q    <= cred_w_d;
            cred_n_q    <= cred_n_d;
            ovf_q       <= ovf_d;
            cnt_q       <= cnt_d;
        end
    end

    assign lnk.out_to_west  = WEST_WIDTH'({cred_w_q, {DATA_WIDTH{1'b0}}});
    assign lnk.out_to_north = NORTH_WIDTH'({cred_n_q, {DATA_WIDTH{1'b0}}});
    assign lnk.out_data     = out_data_q;
    assign lnk.out_src      = out_src_q;
    assign lnk.out_valid    = out_valid_q;
    assign lnk.overflow     = ovf_q;
    assign lnk.word_count   = cnt_q;
endmodule

// File: tb/tb_pe_link_sink1100.sv
// Directed bench for pe_link_sink1100: stimulus pushes expected words into a queue,
// a negedge monitor pops and compares on every out_valid&&out_ready and tallies credit pulses.
module tb_pe_link_sink1100;
    localparam int DW = 128;
    localparam int LW = 130;

    logic clk = 1'b0;
    logic reset;
    logic ap_start;

    always #5 clk = ~clk;

    pe_link_sink1100_if #(.DATA_WIDTH(DW), .WEST_WIDTH(LW), .NORTH_WIDTH(LW)) lnk ();

    pe_link_sink1100 #(
        .DATA_WIDTH(DW), .WEST_WIDTH(LW), .NORTH_WIDTH(LW), .FIFO_ADDR_BITS(2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ap_start (ap_start),
        .lnk      (lnk)
    );

    logic [DW:0] exp_q [$];
    int n_checks   = 0;
    int n_pass     = 0;
    int cred_w_cnt = 0;
    int cred_n_cnt = 0;
    int hs_cnt     = 0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        logic [DW:0] e;
        if (reset) begin
            if (lnk.out_to_west[DW])  cred_w_cnt++;
            if (lnk.out_to_north[DW]) cred_n_cnt++;
            if (lnk.out_valid && lnk.out_ready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_output: got src=%0d data=%0h expected none",
                             lnk.out_src, lnk.out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("stream", {lnk.out_src, lnk.out_data}, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic logic [LW-1:0] word(input logic [DW-1:0] d);
        return {1'b1, 1'b0, d};
    endfunction

    function automatic logic [DW:0] expw(input logic src, input int d);
        logic [DW-1:0] v;
        v = DW'(d);
        return {src, v};
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        ap_start = 1'b0;
        lnk.out_ready = 1'b0;
        lnk.in_from_west = '0;
        lnk.in_from_north = '0;
        exp_q.delete();
        tick();
        cred_w_cnt = 0;
        cred_n_cnt = 0;
        hs_cnt = 0;
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        ap_start = 1'b0;
        lnk.out_ready = 1'b0;
        lnk.in_from_west = '0;
        lnk.in_from_north = '0;
        #2 reset = 1'b0;
        #1;
        check("rst_out_valid", lnk.out_valid, 0);
        check("rst_out_data", lnk.out_data, 0);
        check("rst_out_src", lnk.out_src, 0);
        check("rst_out_to_west", lnk.out_to_west, 0);
        check("rst_out_to_north", lnk.out_to_north, 0);
        check("rst_overflow", lnk.overflow, 0);
        check("rst_word_count", lnk.word_count, 0);

        // Single word
        do_reset();
        ap_start = 1'b1;
        lnk.out_ready = 1'b1;
        lnk.in_from_west = word(DW'('hA5));
        exp_q.push_back(expw(1'b0, 'hA5));
        tick();
        lnk.in_from_west = '0;
        check("single_not_yet_valid", lnk.out_valid, 0);
        tick();
        check("single_valid", lnk.out_valid, 1);
        check("single_data", lnk.out_data, 'hA5);
        check("single_src", lnk.out_src, 0);
        check("single_credit_hi", lnk.out_to_west[DW], 1);
        tick();
        check("single_valid_cleared", lnk.out_valid, 0);
        check("single_credit_lo", lnk.out_to_west[DW], 0);
        check("single_word_count", lnk.word_count, 1);
        check("single_credit_pulses", cred_w_cnt, 1);

        // Arbitration with both links saturated
        do_reset();
        for (int i = 0; i < 4; i++) begin
            lnk.in_from_west  = word(DW'('h100 + i));
            lnk.in_from_north = word(DW'('h200 + i));
            tick();
        end
        lnk.in_from_west = '0;
        lnk.in_from_north = '0;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(expw(1'b0, 'h100 + i));
            exp_q.push_back(expw(1'b1, 'h200 + i));
        end
        ap_start = 1'b1;
        lnk.out_ready = 1'b1;
        ticks(12);
        check("arb_all_seen", exp_q.size(), 0);
        check("arb_west_credits", cred_w_cnt, 4);
        check("arb_north_credits", cred_n_cnt, 4);
        check("arb_word_count", lnk.word_count, 8);
        check("arb_overflow", lnk.overflow, 0);

        // Backpressure and overflow
        do_reset();
        ap_start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            lnk.in_from_west = word(DW'('h300 + i));
            if (i == 4) check("bp_overflow_before_5th", lnk.overflow, 0);
            tick();
            if (i == 4) check("bp_5th_accepted_no_ovf", lnk.overflow, 0);
        end
        lnk.in_from_west = '0;
        check("bp_hold_valid", lnk.out_valid, 1);
        check("bp_hold_data", lnk.out_data, 'h300);
        check("bp_one_pop_credit", cred_w_cnt, 1);
        check("bp_overflow_set", lnk.overflow, 2'b01);
        for (int i = 0; i < 5; i++) exp_q.push_back(expw(1'b0, 'h300 + i));
        lnk.out_ready = 1'b1;
        ticks(10);
        check("bp_drain_all_seen", exp_q.size(), 0);
        check("bp_drain_count", hs_cnt, 5);
        check("bp_word_count", lnk.word_count, 5);
        check("bp_overflow_sticky", lnk.overflow, 2'b01);
        check("bp_west_credits", cred_w_cnt, 5);

        // ap_start gating
        do_reset();
        lnk.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            lnk.in_from_north = word(DW'('h400 + i));
            tick();
        end
        lnk.in_from_north = '0;
        ticks(3);
        check("gate_no_valid", lnk.out_valid, 0);
        check("gate_no_credit", cred_n_cnt, 0);
        check("gate_no_handshake", hs_cnt, 0);
        for (int i = 0; i < 2; i++) exp_q.push_back(expw(1'b1, 'h400 + i));
        ap_start = 1'b1;
        ticks(5);
        check("gate_all_seen", exp_q.size(), 0);
        check("gate_north_credits", cred_n_cnt, 2);
        check("gate_word_count", lnk.word_count, 2);

        // Reset mid-stream
        do_reset();
        for (int i = 0; i < 2; i++) begin
            lnk.in_from_west  = word(DW'('h500 + i));
            lnk.in_from_north = word(DW'('h600 + i));
            tick();
        end
        lnk.in_from_west = '0;
        lnk.in_from_north = '0;
        ap_start = 1'b1;
        tick();
        check("mid_valid_before_reset", lnk.out_valid, 1);
        check("mid_credit_before_reset", lnk.out_to_west[DW], 1);
        exp_q.delete();
        #2 reset = 1'b0;
        #1;
        check("mid_rst_valid", lnk.out_valid, 0);
        check("mid_rst_data", lnk.out_data, 0);
        check("mid_rst_to_west", lnk.out_to_west, 0);
        check("mid_rst_to_north", lnk.out_to_north, 0);
        tick();
        cred_w_cnt = 0;
        cred_n_cnt = 0;
        hs_cnt = 0;
        reset = 1'b1;
        lnk.out_ready = 1'b1;
        ticks(6);
        check("mid_post_no_words", hs_cnt, 0);
        check("mid_post_no_wcred", cred_w_cnt, 0);
        check("mid_post_no_ncred", cred_n_cnt, 0);
        check("mid_post_word_count", lnk.word_count, 0);

        // Full FIFO with push on the pop edge
        do_reset();
        lnk.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            lnk.in_from_west = word(DW'('h700 + i));
            tick();
        end
        ap_start = 1'b1;
        lnk.in_from_west = word(DW'('h704));
        tick();
        lnk.in_from_west = '0;
        check("fullpop_overflow", lnk.overflow, 0);
        for (int i = 0; i < 5; i++) exp_q.push_back(expw(1'b0, 'h700 + i));
        ticks(8);
        check("fullpop_all_seen", exp_q.size(), 0);
        check("fullpop_word_count", lnk.word_count, 5);
        check("fullpop_credits", cred_w_cnt, 5);
        check("fullpop_overflow_end", lnk.overflow, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/pe_link_sink1100.md
# pe_link_sink1100

Receive-side link endpoint for overlay PE tiles. It terminates the west and north inbound mesh links, which are the far ends of a neighbour tile's east and south outputs. Each link is buffered in a small FIFO, and link credits are returned upstream on the reverse bus. The two streams are merged by a round-robin arbiter into one valid/ready stream for the local PE core.

## Interface
Parameters:
- DATA_WIDTH, 128, payload bits per link word
- WEST_WIDTH, 130, west link bus width; must equal DATA_WIDTH+2
- NORTH_WIDTH, 130, north link bus width; must equal DATA_WIDTH+2
- FIFO_ADDR_BITS, 2, log2 of per-link FIFO depth (default depth 4)

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- ap_start  in  1  level enable; pops and output loads occur only while high
- in_from_west  in  WEST_WIDTH  [129]=valid, [128]=unused, [127:0]=payload
- in_from_north  in  NORTH_WIDTH  same format as in_from_west
- out_to_west  out  WEST_WIDTH  [128]=credit pulse; all other bits 0
- out_to_north  out  NORTH_WIDTH  [128]=credit pulse; all other bits 0
- out_data  out  DATA_WIDTH  merged payload
- out_src  out  1  source of out_data: 0=west, 1=north
- out_valid  out  1  out_data/out_src valid
- out_ready  in  1  PE core accepts when out_valid&&out_ready
- overflow  out  2  sticky drop flags: [0]=west, [1]=north
- word_count  out  32  accepted-word count; wraps at 2^32

## Operation
- Push: a link word with valid=1 is written into that link's FIFO at the rising edge.
- Full-FIFO push with a same-cycle pop is accepted.
- Full-FIFO push with no same-cycle pop is dropped, and the link's overflow bit sets. It clears only on reset.
- Output register loads when ap_start=1 and at least one FIFO is non-empty and (out_valid=0 or out_ready=1).
  - A load pops one word from the granted FIFO.
  - It sets out_data/out_src and out_valid=1.
- out_valid clears when out_valid&&out_ready and no new load occurs that edge.
- Arbiter is round-robin with one pointer; reset value = west.
  - The pointer's link is granted if non-empty; otherwise the other link is granted.
  - After each grant the pointer moves to the non-granted link.
  - With both links saturated, grants alternate W,N,W,N.
- Credit: each pop sets that link's credit bit (out_to_west[128] or out_to_north[128]) for exactly one cycle. The bit is registered; two pops on consecutive cycles give two consecutive credit cycles.
- Upstream starts with 2^FIFO_ADDR_BITS credits, so under a correct protocol overflow never sets.
- ap_start low:
  - FIFOs keep accepting pushes.
  - No pops and no credits.
  - A held out_valid stays valid and can still be consumed.
- word_count increments on every out_valid&&out_ready.
- Reset (async assert, any time):
  - FIFOs empty; pointer = west.
  - out_valid=0, out_data=0, out_src=0.
  - Both credit bits 0; overflow=0; word_count=0.
  - Words in flight are discarded and no credits are issued for them.

## Timing
- Link word sampled at edge E is on out_data after edge E+1 at the earliest (FIFO write, then output load).
- Credit bit is high in the cycle following the pop edge.
- Throughput: one word per cycle while out_ready=1 and data is available.
- out_to_* bits other than [128] are constant 0.

## Test plan
- Single word: reset, ap_start=1, west valid with payload 0xA5 for one cycle, then out_ready=1.
  - Required: out_valid with out_data=0xA5, out_src=0 two edges after the push.
  - Required: out_to_west[128] high for one cycle after the pop.
  - Required: word_count=1.
- Arbitration: load west FIFO with W0..W3 and north with N0..N3, then ap_start=1, out_ready=1.
  - Required: output order W0,N0,W1,N1,W2,N2,W3,N3.
  - Required: 4 credit pulses per link; word_count=8.
- Backpressure: out_ready=0 with 4 west words pushed.
  - Required: out holds W0 and one pop has occurred.
  - Required: a 5th push is accepted (occupancy 4) with overflow=0.
  - Required: a 6th push with no pop sets overflow[0] and is lost.
  - Required: draining yields exactly 5 words.
- ap_start gating: push 2 north words with ap_start=0.
  - Required: no out_valid and no credit.
  - Required: after ap_start rises, both words arrive with 2 north credit pulses.
- Reset mid-stream: assert reset while out_valid=1 and both FIFOs are non-empty.
  - Required: all outputs return to reset values immediately.
  - Required: after release, FIFOs are empty and no stale words or credits appear.
- Full with simultaneous pop: west FIFO full with out_ready=1, push on the pop cycle.
  - Required: word accepted and overflow stays 0.
